fetch_unit: RTL

//  Instruction fetch stage, directly upstream of the decoder. Holds the PC and issues in-order

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order word reads to instruction memory and
// buffers returned words with their PCs in a small FIFO feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t         state;
  logic [31:0]    pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop;
  logic [CW-1:0]  count;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [31:0]    fifo_inst [DEPTH];
  logic [31:0]    fifo_pc   [DEPTH];

  logic           resp_ok;
  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  drop_next;
  logic [CW:0]    occupancy;
  logic           push;
  logic           pop;
  logic [31:0]    resp_pc;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Handshakes: imem_req is accepted in any cycle it is high; a decode transfer happens on a
  // cycle where inst_valid and inst_ready are both high, and a redirect cancels that transfer.
  always_comb begin
    resp_ok   = imem_rvalid && (outstanding != '0);
    in_flight = outstanding - CW'(resp_ok);
    drop_next = drop - CW'(resp_ok);
    occupancy = {1'b0, outstanding} + {1'b0, count};
    imem_req  = (state == RUN) && (occupancy < (CW+1)'(DEPTH)) && !redirect_valid;
    imem_addr = pc;
    push      = (state == RUN) && resp_ok && !redirect_valid;
    pop       = (count != '0) && inst_ready && !redirect_valid;
    // Requests since the last redirect are consecutive, so the oldest one sits this far behind pc.
    resp_pc   = pc - (32'(outstanding) << 2);
  end

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo_inst[rd_ptr] : NOP_INST;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : 32'h0;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc & ~32'h3;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= in_flight;
      drop        <= in_flight;
      if (state == IDLE || in_flight == '0) state <= RUN;
      else                                  state <= FLUSH;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (imem_req) pc <= pc + 32'd4;
          outstanding <= outstanding + CW'(imem_req) - CW'(resp_ok);
          if (push) wr_ptr <= ptr_next(wr_ptr);
          if (pop)  rd_ptr <= ptr_next(rd_ptr);
          count <= count + CW'(push) - CW'(pop);
        end
        FLUSH: begin
          // Stale responses are counted off and their data discarded.
          outstanding <= in_flight;
          drop        <= drop_next;
          if (drop_next == '0) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
